// File: rtl/obq_history_writer.sv
// Speculative GHR keeper and OBQ allocator: one checkpoint per predicted branch, repair on mispredict, clear on flush.
// Latency: accept writes the OBQ the same cycle; mispredict repairs the OBQ one cycle later; flush clears it one cycle later.
module obq_history_writer #(
    parameter int OBQ_SIZE = 16,
    parameter int HIST_W   = 8,
    parameter int IDX_W    = $clog2(OBQ_SIZE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              br_valid,
    input  logic              br_pred_taken,
    output logic              br_ready,
    output logic [IDX_W-1:0]  br_tag,
    output logic [HIST_W-1:0] ghr_out,
    input  logic              mispred_valid,
    input  logic [IDX_W-1:0]  mispred_tag,
    input  logic              mispred_taken,
    input  logic              flush,
    output logic [IDX_W-1:0]  obq_rd_index,
    input  logic [HIST_W-1:0] obq_rd_row,
    output logic              obq_write_en,
    output logic [HIST_W-1:0] obq_bh_row,
    output logic              obq_clear_en,
    output logic [IDX_W-1:0]  obq_index
);

    typedef enum logic [1:0] {ST_IDLE, ST_RECOVER, ST_FLUSH} state_t;

    localparam logic [IDX_W:0] TAIL_MAX = (IDX_W+1)'(OBQ_SIZE);

    state_t             state_q, state_d;
    logic [HIST_W-1:0]  ghr_q, ghr_d;
    logic [IDX_W:0]     tail_q, tail_d;
    logic [IDX_W-1:0]   pend_tag_q, pend_tag_d;
    logic [HIST_W-1:0]  pend_row_q, pend_row_d;
    logic               pend_taken_q, pend_taken_d;
    logic               accept;
    logic               tag_live;

    assign ghr_out      = ghr_q;
    assign br_tag       = tail_q[IDX_W-1:0];
    assign obq_rd_index = mispred_tag;

    always_comb begin
        state_d      = state_q;
        ghr_d        = ghr_q;
        tail_d       = tail_q;
        pend_tag_d   = pend_tag_q;
        pend_row_d   = pend_row_q;
        pend_taken_d = pend_taken_q;

        br_ready = (state_q == ST_IDLE) && !mispred_valid && !flush && (tail_q < TAIL_MAX);
        accept   = br_valid && br_ready;
        tag_live = {1'b0, mispred_tag} < tail_q;

        obq_write_en = accept;
        obq_clear_en = 1'b0;
        obq_index    = tail_q[IDX_W-1:0];
        obq_bh_row   = ghr_q;

        // Rewriting the mispredicted slot with its own checkpoint keeps it while the clear kills younger ones.
        case (state_q)
            ST_RECOVER: begin
                obq_clear_en = 1'b1;
                obq_write_en = 1'b1;
                obq_index    = pend_tag_q;
                obq_bh_row   = pend_row_q;
            end
            ST_FLUSH: begin
                obq_clear_en = 1'b1;
                obq_write_en = 1'b0;
                obq_index    = '0;
            end
            default: ;
        endcase

        if (flush) begin
            state_d = ST_FLUSH;
            if (state_q == ST_FLUSH) begin
                ghr_d  = '0;
                tail_d = '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mispred_valid) begin
                        if (tag_live) begin
                            pend_tag_d   = mispred_tag;
                            pend_row_d   = obq_rd_row;
                            pend_taken_d = mispred_taken;
                            state_d      = ST_RECOVER;
                        end
                    end else if (accept) begin
                        ghr_d  = {ghr_q[HIST_W-2:0], br_pred_taken};
                        tail_d = tail_q + (IDX_W+1)'(1);
                    end
                end
                ST_RECOVER: begin
                    // An older mispredict supersedes the pending one; younger ones are already doomed.
                    if (mispred_valid && (mispred_tag < pend_tag_q)) begin
                        pend_tag_d   = mispred_tag;
                        pend_row_d   = obq_rd_row;
                        pend_taken_d = mispred_taken;
                    end else begin
                        ghr_d   = {pend_row_q[HIST_W-2:0], pend_taken_q};
                        tail_d  = (IDX_W+1)'(pend_tag_q) + (IDX_W+1)'(1);
                        state_d = ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    ghr_d   = '0;
                    tail_d  = '0;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ghr_q        <= '0;
            tail_q       <= '0;
            pend_tag_q   <= '0;
            pend_row_q   <= '0;
            pend_taken_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ghr_q        <= ghr_d;
            tail_q       <= tail_d;
            pend_tag_q   <= pend_tag_d;
            pend_row_q   <= pend_row_d;
            pend_taken_q <= pend_taken_d;
        end
    end

endmodule

// File: tb/tb_obq_history_writer.sv
// Bench for obq_history_writer: a queue of checkpoints stands in for the OBQ and predicts every output each cycle.
module tb_obq_history_writer;

    logic       clock = 1'b0;
    logic       reset;
    logic       br_valid, br_pred_taken, br_ready;
    logic [3:0] br_tag;
    logic [7:0] ghr_out;
    logic       mispred_valid, mispred_taken, flush;
    logic [3:0] mispred_tag, obq_rd_index, obq_index;
    logic [7:0] obq_rd_row, obq_bh_row;
    logic       obq_write_en, obq_clear_en;

    always #5 clock = ~clock;

    obq_history_writer #(.OBQ_SIZE(16), .HIST_W(8)) dut (
        .clock(clock), .reset(reset),
        .br_valid(br_valid), .br_pred_taken(br_pred_taken), .br_ready(br_ready),
        .br_tag(br_tag), .ghr_out(ghr_out),
        .mispred_valid(mispred_valid), .mispred_tag(mispred_tag), .mispred_taken(mispred_taken),
        .flush(flush), .obq_rd_index(obq_rd_index), .obq_rd_row(obq_rd_row),
        .obq_write_en(obq_write_en), .obq_bh_row(obq_bh_row),
        .obq_clear_en(obq_clear_en), .obq_index(obq_index)
    );

    // Model: m_q holds the live checkpoints (its size is the tail); m_mode 0=normal, 1=repairing, 2=flushing.
    logic [7:0] m_hist = 8'h00;
    logic [7:0] m_q[$];
    int         m_mode = 0;
    int         m_rtag = 0;
    logic [7:0] m_rrow = 8'h00;
    logic       m_rtaken = 1'b0;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic cyc(input bit bv, input bit bt, input bit mv, input int mt,
                       input bit mk, input bit fl, input bit rst);
        int sz;
        bit rdy;
        @(negedge clock);
        br_valid      = bv;
        br_pred_taken = bt;
        mispred_valid = mv;
        mispred_tag   = 4'(mt);
        mispred_taken = mk;
        flush         = fl;
        reset         = rst;
        sz = m_q.size();
        obq_rd_row = (mt < sz) ? m_q[mt] : 8'($urandom);
        #1;
        rdy = (m_mode == 0) && !mv && !fl && (sz < 16);
        chk("br_ready", int'(br_ready), int'(rdy));
        chk("ghr_out", int'(ghr_out), int'(m_hist));
        chk("obq_rd_index", int'(obq_rd_index), mt);
        case (m_mode)
            0: begin
                chk("write_en", int'(obq_write_en), int'(bv && rdy));
                chk("clear_en", int'(obq_clear_en), 0);
                chk("obq_index", int'(obq_index), sz % 16);
                if (bv && rdy) begin
                    chk("br_tag", int'(br_tag), sz);
                    chk("bh_row", int'(obq_bh_row), int'(m_hist));
                end
            end
            1: begin
                chk("rec_write_en", int'(obq_write_en), 1);
                chk("rec_clear_en", int'(obq_clear_en), 1);
                chk("rec_index", int'(obq_index), m_rtag);
                chk("rec_bh_row", int'(obq_bh_row), int'(m_rrow));
            end
            default: begin
                chk("fl_write_en", int'(obq_write_en), 0);
                chk("fl_clear_en", int'(obq_clear_en), 1);
                chk("fl_index", int'(obq_index), 0);
            end
        endcase

        if (!rst) begin
            m_hist = 8'h00; m_q.delete(); m_mode = 0;
            m_rtag = 0; m_rrow = 8'h00; m_rtaken = 1'b0;
        end else if (fl) begin
            if (m_mode == 2) begin m_hist = 8'h00; m_q.delete(); end
            m_mode = 2;
        end else if (m_mode == 0) begin
            if (mv) begin
                if (mt < sz) begin
                    m_rtag = mt; m_rrow = m_q[mt]; m_rtaken = mk; m_mode = 1;
                end
            end else if (bv && rdy) begin
                m_q.push_back(m_hist);
                m_hist = {m_hist[6:0], bt};
            end
        end else if (m_mode == 1) begin
            if (mv && mt < m_rtag) begin
                m_rtag = mt; m_rrow = m_q[mt]; m_rtaken = mk;
            end else begin
                while (m_q.size() > m_rtag + 1) m_q.pop_back();
                m_hist = {m_rrow[6:0], m_rtaken};
                m_mode = 0;
            end
        end else begin
            m_hist = 8'h00; m_q.delete(); m_mode = 0;
        end
    endtask

    task automatic br(input bit t);
        cyc(1'b1, t, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic mis(input int tag, input bit tk);
        cyc(1'b0, 1'b0, 1'b1, tag, tk, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; br_valid = 1'b0; br_pred_taken = 1'b0; mispred_valid = 1'b0;
        mispred_tag = 4'd0; mispred_taken = 1'b0; flush = 1'b0; obq_rd_row = 8'h00;
        repeat (2) @(posedge clock);

        // Reset state and three branches T,N,T.
        do_reset();
        idle();
        chk("lit_reset_ready", int'(br_ready), 1);
        chk("lit_reset_strobes", int'({obq_write_en, obq_clear_en}), 0);
        br(1'b1); chk("lit_tag0", int'(br_tag), 0); chk("lit_row0", int'(obq_bh_row), 8'h00);
        br(1'b0); chk("lit_tag1", int'(br_tag), 1); chk("lit_row1", int'(obq_bh_row), 8'h01);
        br(1'b1); chk("lit_tag2", int'(br_tag), 2); chk("lit_row2", int'(obq_bh_row), 8'h02);
        idle();   chk("lit_ghr05", int'(ghr_out), 8'h05); chk("lit_tail3", int'(br_tag), 3);

        // Fill to 16, then a held 17th branch.
        do_reset();
        for (int i = 0; i < 16; i++) br(1'($urandom));
        br(1'b1);
        chk("lit_full_ready", int'(br_ready), 0);
        chk("lit_full_nowrite", int'(obq_write_en), 0);

        // Tail 5 with ghr 0x1A, mispredict tag 2 not-taken.
        do_reset();
        br(1'b1); br(1'b1); br(1'b0); br(1'b1); br(1'b0);
        idle(); chk("lit_ghr1a", int'(ghr_out), 8'h1A);
        mis(2, 1'b0);
        idle();
        chk("lit_rec_clr", int'(obq_clear_en), 1);
        chk("lit_rec_idx", int'(obq_index), 2);
        chk("lit_rec_row", int'(obq_bh_row), 8'h03);
        chk("lit_rec_ready", int'(br_ready), 0);
        idle();
        chk("lit_ghr06", int'(ghr_out), 8'h06);
        chk("lit_tail_after", int'(br_tag), 3);
        chk("lit_ready_n2", int'(br_ready), 1);

        // Out-of-range mispredict is dropped.
        mis(7, 1'b1);
        idle();
        chk("lit_drop_strobes", int'({obq_write_en, obq_clear_en}), 0);
        chk("lit_drop_ghr", int'(ghr_out), 8'h06);

        // Older mispredict during recovery takes over.
        br(1'b1); br(1'b0); br(1'b1);
        mis(4, 1'b1);
        mis(1, 1'b0); chk("lit_rec_first", int'(obq_index), 4);
        idle();       chk("lit_rec_second", int'(obq_index), 1);
        idle();       chk("lit_tail2", int'(br_tag), 2);

        // Flush during recovery, then reset during flush.
        br(1'b1); br(1'b1);
        mis(1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("lit_fl_clr", int'(obq_clear_en), 1);
        chk("lit_fl_idx", int'(obq_index), 0);
        chk("lit_fl_we", int'(obq_write_en), 0);
        idle();
        chk("lit_fl_ghr", int'(ghr_out), 0);
        chk("lit_fl_tail", int'(br_tag), 0);
        br(1'b1); br(1'b1);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b1);
        do_reset();
        idle();
        chk("lit_rst_ghr", int'(ghr_out), 0);
        chk("lit_rst_ready", int'(br_ready), 1);
        chk("lit_rst_clr", int'(obq_clear_en), 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 70), 1'($urandom),
                ($urandom_range(0, 99) < 10), $urandom_range(0, 15), 1'($urandom),
                ($urandom_range(0, 99) < 3), !($urandom_range(0, 199) < 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
